axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameters: none; 2 requesters, 32-bit address/data, 8-bit AWLEN fixed.
REQ-002 ACLK  input  1  clock, all logic on rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 S_AWADDR  input  64  requester write addresses; [31:0]=S0, [63:32]=S1.
REQ-005 S_AWLEN  input  16  requester burst lengths minus one; [7:0]=S0.
REQ-006 S_AWVALID  input  2  per-requester address valid.
REQ-007 S_AWREADY  output  2  per-requester address ready.
REQ-008 S_WDATA  input  64  requester write data; [31:0]=S0.
REQ-009 S_WVALID  input  2  per-requester data valid.
REQ-010 S_WREADY  output  2  per-requester data ready.
REQ-011 S_WLAST  input  2  per-requester last beat; ignored for sequencing.
REQ-012 S_BRESP  output  4  per-requester write response; [1:0]=S0.
REQ-013 S_BVALID  output  2  per-requester response valid, one-cycle pulse.
REQ-014 M_AWADDR, M_AWLEN, M_AWVALID  output  32/8/1  shared address channel.
REQ-015 M_AWREADY  input  1  shared address ready.
REQ-016 M_WDATA, M_WVALID, M_WLAST  output  32/1/1  shared data channel.
REQ-017 M_WREADY  input  1  shared data ready.
REQ-018 M_BRESP  input  2  shared write response; M_BVALID  input  1  response valid, no BREADY, accepted unconditionally.
REQ-019 GRANT  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-020 FSM states IDLE, ADDR, DATA, RESP; one transaction (AW, all W beats, B) owns the port end to end, no interleaving.
REQ-021 IDLE: if any S_AWVALID set, register winner into GRANT, latch its AWLEN into len_q, clear beat counter, go ADDR next edge.
REQ-022 Arbitration round-robin: both requesting -> requester not granted last wins; pointer after reset favours S0.
REQ-023 ADDR: M_AWADDR/M_AWLEN/M_AWVALID combinationally from granted requester; S_AWREADY[g]=M_AWREADY; on M_AWVALID&&M_AWREADY go DATA.
REQ-024 DATA: M_WDATA/M_WVALID from granted requester; S_WREADY[g]=M_WREADY; beat counter (8-bit) increments per W handshake.
REQ-025 M_WLAST = M_WVALID && (beat counter == len_q), generated internally; handshake on that beat goes RESP.
REQ-026 RESP: S_BVALID[g]=M_BVALID, S_BRESP[g]=M_BRESP; on M_BVALID go IDLE, round-robin pointer := g.
REQ-027 Non-granted requester: AWREADY, WREADY, BVALID = 0, BRESP = 0 at all times.
REQ-028 Outside ADDR, M_AWVALID=0; outside DATA, M_WVALID=0, M_WLAST=0, S_WREADY=0 (early W data stalls until DATA).
REQ-029 Latency: S_AWVALID rising in IDLE -> M_AWVALID high exactly 1 cycle later; RESP->IDLE->next grant minimum 2 cycles between transactions.
REQ-030 Requester dropping AWVALID in ADDR: arbiter keeps GRANT; address pass-through continues (protocol violation not checked).
REQ-031 M_BVALID arriving outside RESP ignored, not routed.
REQ-032 AWLEN=0: single-beat burst, M_WLAST on first beat.

Reset
REQ-033 ARESETn low: state IDLE, GRANT=0, all outputs 0, beat counter 0, len_q 0, pointer favours S0; takes effect asynchronously, including mid-burst.
REQ-034 Release: first arbitration on first rising edge with ARESETn high.

Verification
REQ-035 S0 only, AWADDR=0x1000, AWLEN=15, WREADY always 1 -> GRANT=01 after 1 cycle, 16 beats, M_WLAST on beat 16, S_BVALID[0] pulse with M_BRESP=00.
REQ-036 S0 and S1 AWVALID same cycle after reset -> S0 served first, S1 next; repeat -> S1 first then S0.
REQ-037 S1 burst AWLEN=3 with M_WREADY toggling 1/0 -> exactly 4 M_WDATA handshakes, S_WREADY[0]=0 throughout.
REQ-038 AWLEN=0 on S1, M_BRESP=10 -> one beat with M_WLAST=1, S_BRESP[3:2]=10, S_BVALID=10.
REQ-039 ARESETn low at beat 5 of 16 -> all outputs 0 immediately; after release S1-pending request granted cleanly with beat counter from 0.
REQ-040 Spurious M_BVALID in IDLE and DATA -> no S_BVALID, state unchanged.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester round-robin AXI write-channel arbiter
module axi_wr_arbiter (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [63:0] S_AWADDR,
    input  logic [15:0] S_AWLEN,
    input  logic [1:0]  S_AWVALID,
    output logic [1:0]  S_AWREADY,
    input  logic [63:0] S_WDATA,
    input  logic [1:0]  S_WVALID,
    output logic [1:0]  S_WREADY,
    input  logic [1:0]  S_WLAST,
    output logic [3:0]  S_BRESP,
    output logic [1:0]  S_BVALID,
    output logic [31:0] M_AWADDR,
    output logic [7:0]  M_AWLEN,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic        M_WVALID,
    output logic        M_WLAST,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic [1:0]  GRANT
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        last_q, last_d;
    logic        g;
    logic        pick;
    logic        unused_wlast;

    // Write sequencing uses the latched burst length, so requester WLAST is not needed.
    assign unused_wlast = &{1'b0, S_WLAST};

    assign g     = grant_q[1];
    assign GRANT = grant_q;
    // last_q holds the index of the last owner; reset value 1 makes S0 win the first tie.
    assign pick  = (S_AWVALID == 2'b11) ? ~last_q : S_AWVALID[1];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        len_d     = len_q;
        beat_d    = beat_q;
        last_d    = last_q;
        S_AWREADY = 2'b00;
        S_WREADY  = 2'b00;
        S_BRESP   = 4'b0000;
        S_BVALID  = 2'b00;
        M_AWADDR  = 32'd0;
        M_AWLEN   = 8'd0;
        M_AWVALID = 1'b0;
        M_WDATA   = 32'd0;
        M_WVALID  = 1'b0;
        M_WLAST   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|S_AWVALID) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    len_d   = pick ? S_AWLEN[15:8] : S_AWLEN[7:0];
                    beat_d  = 8'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                M_AWADDR  = g ? S_AWADDR[63:32] : S_AWADDR[31:0];
                M_AWLEN   = g ? S_AWLEN[15:8] : S_AWLEN[7:0];
                M_AWVALID = 1'b1;
                S_AWREADY = g ? {M_AWREADY, 1'b0} : {1'b0, M_AWREADY};
                if (M_AWREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                M_WDATA  = g ? S_WDATA[63:32] : S_WDATA[31:0];
                M_WVALID = g ? S_WVALID[1] : S_WVALID[0];
                M_WLAST  = M_WVALID && (beat_q == len_q);
                S_WREADY = g ? {M_WREADY, 1'b0} : {1'b0, M_WREADY};
                if (M_WVALID && M_WREADY) begin
                    beat_d = beat_q + 8'd1;
                    if (M_WLAST) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                S_BVALID = g ? {M_BVALID, 1'b0} : {1'b0, M_BVALID};
                S_BRESP  = g ? {M_BRESP, 2'b00} : {2'b00, M_BRESP};
                if (M_BVALID) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - self-checking bench for axi_wr_arbiter
module tb_axi_wr_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [63:0] s_awaddr;
    logic [15:0] s_awlen;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, grant;
    logic [63:0] s_wdata;
    logic [3:0]  s_bresp;
    logic [31:0] m_awaddr, m_wdata;
    logic [7:0]  m_awlen;
    logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid;
    logic [1:0]  m_bresp;

    int nerr = 0;
    int nchk = 0;

    axi_wr_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WVALID(s_wvalid), .S_WREADY(s_wready), .S_WLAST(s_wlast),
        .S_BRESP(s_bresp), .S_BVALID(s_bvalid),
        .M_AWADDR(m_awaddr), .M_AWLEN(m_awlen), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WVALID(m_wvalid), .M_WLAST(m_wlast), .M_WREADY(m_wready),
        .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .GRANT(grant)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0] awv;
        logic       mawr, mwr, mbv;
        logic [1:0] mbresp;
        logic [1:0] grant;
        logic       mawv, mwv, wlast;
        logic [1:0] swr, sbv;
        logic [3:0] sbresp;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        s_awaddr = '0; s_awlen = '0; s_awvalid = '0; s_wdata = '0; s_wvalid = '0; s_wlast = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        zero_inputs();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // Drives one granted burst from requester `who` until its B pulse completes.
    task automatic run_txn(input int who, input bit toggle, input int stop_at,
                           output int beats, output int last_at, output int bv_cnt,
                           output logic [1:0] bresp, output int other_wr);
        int  wsent;
        bit  awdrop;
        wsent = 0; awdrop = 0;
        beats = 0; last_at = 0; bv_cnt = 0; bresp = '0; other_wr = 0;
        for (int c = 0; c < 200; c++) begin
            m_wready = toggle ? c[0] : 1'b1;
            s_wdata[who*32 +: 32] = 32'hD000_0000 + wsent;
            s_wvalid[who] = 1'b1;
            #1;
            if (s_awvalid[who] && s_awready[who]) awdrop = 1;
            if (m_wvalid && m_wready) begin
                chk("burst_wdata", m_wdata, 32'hD000_0000 + wsent);
                wsent++;
                beats++;
                if (m_wlast) last_at = beats;
            end
            if (s_wready[1-who]) other_wr++;
            if (s_bvalid[who]) begin
                bv_cnt++;
                bresp = s_bresp[who*2 +: 2];
            end
            if (stop_at != 0 && beats == stop_at) break;
            if (bv_cnt > 0 && s_bvalid == 2'b00 && grant == 2'b00) break;
            @(negedge ACLK);
            if (awdrop) s_awvalid[who] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, last_at, bv_cnt, other_wr, ntx, owner, last_own;
        logic [1:0] bresp;
        logic [31:0] raddr [2];
        logic [7:0]  rlen [2];
        bit          ract [2], rawd [2];
        int          rsent [2];
        logic [1:0]  e_grant, e_sawr, e_swr, e_sbv;
        logic        e_awv, e_wv, e_wlast;
        logic [3:0]  e_sbresp;

        // awv mawr mwr mbv mbresp | grant mawv mwv wlast swr sbv sbresp  (len S0=1, S1=0)
        tbl[0]  = '{2'b00, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[1]  = '{2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[2]  = '{2'b10, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[3]  = '{2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[4]  = '{2'b00, 0, 0, 1, 2'b10, 2'b10, 0, 1, 1, 2'b00, 2'b00, 4'b0000};
        tbl[5]  = '{2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 1, 1, 2'b10, 2'b00, 4'b0000};
        tbl[6]  = '{2'b00, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[7]  = '{2'b00, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 2'b00, 2'b10, 4'b1000};
        tbl[8]  = '{2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[9]  = '{2'b11, 1, 0, 0, 2'b00, 2'b01, 1, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[10] = '{2'b10, 0, 1, 0, 2'b00, 2'b01, 0, 1, 0, 2'b01, 2'b00, 4'b0000};
        tbl[11] = '{2'b10, 0, 1, 0, 2'b00, 2'b01, 0, 1, 1, 2'b01, 2'b00, 4'b0000};
        tbl[12] = '{2'b10, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b01, 4'b0000};
        tbl[13] = '{2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[14] = '{2'b10, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 2'b00, 2'b00, 4'b0000};

        do_reset();
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_outputs", {s_awready, s_wready, s_bvalid, s_bresp, m_awvalid, m_wvalid, m_wlast}, '0);

        s_awaddr = {32'h2000_0000, 32'h0000_1000};
        s_awlen  = {8'd0, 8'd1};
        s_wdata  = {32'hBBBB_0001, 32'hAAAA_0000};
        s_wvalid = 2'b11;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge ACLK);
            s_awvalid = tbl[i].awv; m_awready = tbl[i].mawr; m_wready = tbl[i].mwr;
            m_bvalid = tbl[i].mbv; m_bresp = tbl[i].mbresp;
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_m_awvalid", i), m_awvalid, tbl[i].mawv);
            chk($sformatf("tbl%0d_m_wvalid", i), m_wvalid, tbl[i].mwv);
            chk($sformatf("tbl%0d_m_wlast", i), m_wlast, tbl[i].wlast);
            chk($sformatf("tbl%0d_s_wready", i), s_wready, tbl[i].swr);
            chk($sformatf("tbl%0d_s_bvalid", i), s_bvalid, tbl[i].sbv);
            chk($sformatf("tbl%0d_s_bresp", i), s_bresp, tbl[i].sbresp);
        end

        // 16-beat S0 burst with WREADY always high.
        do_reset();
        s_awaddr[31:0] = 32'h0000_1000; s_awlen[7:0] = 8'd15; s_awvalid = 2'b01;
        m_awready = 1; m_bvalid = 1; m_bresp = 2'b00;
        #1;
        chk("s0_grant_before_edge", grant, 2'b00);
        @(negedge ACLK); #1;
        chk("s0_grant_after_1", grant, 2'b01);
        chk("s0_awvalid_latency", m_awvalid, 1'b1);
        chk("s0_awaddr", m_awaddr, 32'h0000_1000);
        chk("s0_awlen", m_awlen, 8'd15);
        run_txn(0, 0, 0, beats, last_at, bv_cnt, bresp, other_wr);
        chk("s0_beats", beats, 16);
        chk("s0_wlast_beat", last_at, 16);
        chk("s0_bvalid_pulses", bv_cnt, 1);
        chk("s0_bresp", bresp, 2'b00);
        chk("s0_other_wready", other_wr, 0);

        // Reset at beat 5 of S0 while S1 waits; S1 then bursts under toggling WREADY.
        do_reset();
        s_awaddr = {32'h2000_0000, 32'h0000_1000}; s_awlen = {8'd3, 8'd15};
        s_awvalid = 2'b11; m_awready = 1; m_bvalid = 0;
        run_txn(0, 0, 5, beats, last_at, bv_cnt, bresp, other_wr);
        chk("rst_pre_beats", beats, 5);
        @(negedge ACLK);
        ARESETn = 1'b0;
        s_awvalid = 2'b10;
        #1;
        chk("rst_async_grant", grant, 2'b00);
        chk("rst_async_outputs", {s_awready, s_wready, s_bvalid, s_bresp, m_awvalid, m_wvalid, m_wlast}, '0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("rst_release_idle", grant, 2'b00);
        @(negedge ACLK); #1;
        chk("rst_s1_grant", grant, 2'b10);
        chk("rst_s1_awlen", m_awlen, 8'd3);
        chk("rst_s1_awaddr", m_awaddr, 32'h2000_0000);
        m_bvalid = 1; m_bresp = 2'b01;
        run_txn(1, 1, 0, beats, last_at, bv_cnt, bresp, other_wr);
        chk("s1_toggle_beats", beats, 4);
        chk("s1_toggle_wlast_beat", last_at, 4);
        chk("s1_bvalid_pulses", bv_cnt, 1);
        chk("s1_bresp", bresp, 2'b01);
        chk("s1_s0_wready_quiet", other_wr, 0);

        // Randomized traffic against a transaction-level model.
        do_reset();
        owner = -1; last_own = 1; ntx = 0;
        for (int i = 0; i < 2; i++) begin ract[i] = 0; rawd[i] = 0; rsent[i] = 0; raddr[i] = '0; rlen[i] = '0; end
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge ACLK);
            for (int i = 0; i < 2; i++) begin
                if (!ract[i] && $urandom_range(0, 3) == 0) begin
                    ract[i] = 1; rawd[i] = 0; rsent[i] = 0;
                    raddr[i] = $urandom;
                    rlen[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
                end
                s_awvalid[i] = ract[i] && !rawd[i];
                s_awaddr[i*32 +: 32] = raddr[i];
                s_awlen[i*8 +: 8] = rlen[i];
                s_wvalid[i] = ract[i] && (rsent[i] <= int'(rlen[i])) && ($urandom_range(0, 3) != 0);
                s_wdata[i*32 +: 32] = raddr[i] ^ 32'(rsent[i]);
                s_wlast[i] = (rsent[i] == int'(rlen[i]));
            end
            m_awready = 1'($urandom_range(0, 1));
            m_wready  = ($urandom_range(0, 3) != 0);
            m_bvalid  = 1'($urandom_range(0, 1));
            m_bresp   = 2'($urandom);
            #1;
            e_grant = '0; e_sawr = '0; e_swr = '0; e_sbv = '0; e_sbresp = '0;
            e_awv = 0; e_wv = 0; e_wlast = 0;
            if (owner >= 0) begin
                e_grant[owner] = 1'b1;
                if (!rawd[owner]) begin
                    e_awv = 1;
                    e_sawr[owner] = m_awready;
                    chk("rand_awaddr", m_awaddr, raddr[owner]);
                    chk("rand_awlen", m_awlen, rlen[owner]);
                end else if (rsent[owner] <= int'(rlen[owner])) begin
                    e_wv = s_wvalid[owner];
                    e_wlast = e_wv && (rsent[owner] == int'(rlen[owner]));
                    e_swr[owner] = m_wready;
                    if (e_wv) chk("rand_wdata", m_wdata, raddr[owner] ^ 32'(rsent[owner]));
                end else begin
                    e_sbv[owner] = m_bvalid;
                    e_sbresp[owner*2 +: 2] = m_bresp;
                end
            end
            chk("rand_grant", grant, e_grant);
            chk("rand_m_awvalid", m_awvalid, e_awv);
            chk("rand_m_wvalid", m_wvalid, e_wv);
            chk("rand_m_wlast", m_wlast, e_wlast);
            chk("rand_s_awready", s_awready, e_sawr);
            chk("rand_s_wready", s_wready, e_swr);
            chk("rand_s_bvalid", s_bvalid, e_sbv);
            chk("rand_s_bresp", s_bresp, e_sbresp);
            if (owner < 0) begin
                if (s_awvalid == 2'b11) owner = (last_own == 0) ? 1 : 0;
                else if (s_awvalid != 2'b00) owner = s_awvalid[1] ? 1 : 0;
            end else if (!rawd[owner]) begin
                if (m_awready) rawd[owner] = 1;
            end else if (rsent[owner] <= int'(rlen[owner])) begin
                if (s_wvalid[owner] && m_wready) rsent[owner]++;
            end else if (m_bvalid) begin
                ract[owner] = 0;
                last_own = owner;
                owner = -1;
                ntx++;
            end
        end
        chk("rand_progress", ntx > 50, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
